// File: rtl/meteo_pkg.sv
// Shared constants for the BME280 measurement sequencer: FSM encoding, register map,
// byte counts, raw-field slicing and the byte-controller command bundle.
package meteo_pkg;

  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_W_ADDR  = 4'd1;
  localparam logic [3:0] ST_W_REG   = 4'd2;
  localparam logic [3:0] ST_W_DATA  = 4'd3;
  localparam logic [3:0] ST_W_WAIT  = 4'd4;
  localparam logic [3:0] ST_R_ADDRW = 4'd5;
  localparam logic [3:0] ST_R_REG   = 4'd6;
  localparam logic [3:0] ST_R_ADDRR = 4'd7;
  localparam logic [3:0] ST_R_BYTE  = 4'd8;
  localparam logic [3:0] ST_LATCH   = 4'd9;
  localparam logic [3:0] ST_ABORT   = 4'd10;

  localparam logic [7:0] REG_CTRL_HUM  = 8'hF2;
  localparam logic [7:0] REG_CTRL_MEAS = 8'hF4;
  localparam logic [7:0] REG_DATA      = 8'hF7;

  localparam int NBYTES_PT  = 6;
  localparam int NBYTES_HUM = 8;

  // Byte offsets of each raw field inside the burst-read buffer
  localparam int PRESS_IDX = 0;
  localparam int TEMP_IDX  = 3;
  localparam int HUM_IDX   = 6;
  localparam int RAW_PT_W  = 20;
  localparam int RAW_HUM_W = 16;

  typedef struct packed {
    logic       start;
    logic       stop;
    logic       read;
    logic       write;
    logic       ack_in;
    logic [7:0] din;
  } cmd_t;

  // 20-bit raw word: msb, lsb and the upper nibble of xlsb
  function automatic logic [RAW_PT_W-1:0] raw20(input logic [7:0] msb,
                                                input logic [7:0] lsb,
                                                input logic [7:0] xlsb);
    return {msb, lsb, xlsb[7:4]};
  endfunction

endpackage

// File: rtl/meteo_rx_buf.sv
// Indexed byte capture register file, cleared at the start of each measurement.
// One write per cycle, zero-latency packed readout (byte i at bits [8*i+:8]).
module meteo_rx_buf #(
  parameter int DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               wr_en,
  input  logic [2:0]         wr_idx,
  input  logic [7:0]         wr_dat,
  output logic [DEPTH*8-1:0] bytes_dat
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (clr)
          mem_q[i] <= 8'h00;
        else if (wr_en && wr_idx == 3'(i))
          mem_q[i] <= wr_dat;
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_pack
    assign bytes_dat[8*g +: 8] = mem_q[g];
  end

endmodule

// File: rtl/meteo_i2c_seq.sv
// BME280 forced-measurement sequencer driving i2c_master_byte_ctrl; one run per Start_i.
// Registered outputs; each command holds until CmdAck_i. METEO_HUM_EN adds humidity.
module meteo_i2c_seq
  import meteo_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR = 7'h76,
  parameter logic [7:0]  CTRL_MEAS  = 8'h25,
  parameter logic [7:0]  CTRL_HUM   = 8'h01,
  parameter logic [15:0] CONV_WAIT  = 16'd10000
) (
  input  logic        Clk_i,
  input  logic        Rst_n_i,
  input  logic        Start_i,
  output logic        Start_o,
  output logic        Stop_o,
  output logic        Read_o,
  output logic        Write_o,
  output logic        AckIn_o,
  output logic [7:0]  Din_o,
  input  logic        CmdAck_i,
  input  logic        AckOut_i,
  input  logic [7:0]  Dout_i,
  input  logic        Al_i,
  output logic        Enable_i2c_o,
  output logic [19:0] Press_o,
  output logic [19:0] Temp_o,
`ifdef METEO_HUM_EN
  output logic [15:0] Hum_o,
`endif
  output logic        Valid_o,
  output logic        ErrFlag_o
);

`ifdef METEO_HUM_EN
  localparam int NBYTES = NBYTES_HUM;
  localparam int WR_LEN = 4;
`else
  localparam int NBYTES = NBYTES_PT;
  localparam int WR_LEN = 2;
`endif
  localparam logic [1:0]  WR_LAST   = 2'(WR_LEN - 1);
  localparam logic [2:0]  RD_LAST   = 3'(NBYTES - 1);
  localparam logic [15:0] WAIT_LAST = (CONV_WAIT == 16'd0) ? 16'd0 : CONV_WAIT - 16'd1;

  logic [3:0]          state_q;
  logic [15:0]         wait_cnt_q;
  logic [1:0]          wr_idx_q;
  logic [2:0]          rd_idx_q;
  cmd_t                cmd_q, cmd_nxt;
  logic [19:0]         press_q, temp_q;
  logic                valid_q, err_q, en_q;
  logic [7:0]          wr_entry;
  logic                wr_last, rd_last, cmd_busy, cmd_issue, cmd_done, nack, accept, rx_wr;
  logic [NBYTES*8-1:0] rx_dat;

  assign wr_last   = (wr_idx_q == WR_LAST);
  assign rd_last   = (rd_idx_q == RD_LAST);
  assign cmd_busy  = cmd_q.start | cmd_q.stop | cmd_q.read | cmd_q.write;
  assign cmd_issue = cmd_nxt.start | cmd_nxt.stop | cmd_nxt.read | cmd_nxt.write;
  assign cmd_done  = cmd_busy && CmdAck_i;
  assign nack      = cmd_done && cmd_q.write && AckOut_i;
  // A Start_i landing on the Valid_o cycle is dropped on purpose
  assign accept    = (state_q == ST_IDLE) && Start_i && !valid_q && !Al_i;
  assign rx_wr     = (state_q == ST_R_BYTE) && cmd_q.read && CmdAck_i;

  // Write list is consumed as (register, value) pairs in a single transaction
  always_comb begin
    wr_entry = 8'h00;
`ifdef METEO_HUM_EN
    case (wr_idx_q)
      2'd0:    wr_entry = REG_CTRL_HUM;
      2'd1:    wr_entry = CTRL_HUM;
      2'd2:    wr_entry = REG_CTRL_MEAS;
      default: wr_entry = CTRL_MEAS;
    endcase
`else
    wr_entry = wr_idx_q[0] ? CTRL_MEAS : REG_CTRL_MEAS;
`endif
  end

  always_comb begin
    cmd_nxt = '0;
    case (state_q)
      ST_W_ADDR: begin
        cmd_nxt.start = 1'b1;
        cmd_nxt.write = 1'b1;
        cmd_nxt.din   = {SLAVE_ADDR, 1'b0};
      end
      ST_W_REG, ST_W_DATA: begin
        cmd_nxt.write = 1'b1;
        cmd_nxt.stop  = (state_q == ST_W_DATA) && wr_last;
        cmd_nxt.din   = wr_entry;
      end
      ST_R_ADDRW: begin
        cmd_nxt.start = 1'b1;
        cmd_nxt.write = 1'b1;
        cmd_nxt.din   = {SLAVE_ADDR, 1'b0};
      end
      ST_R_REG: begin
        cmd_nxt.write = 1'b1;
        cmd_nxt.din   = REG_DATA;
      end
      ST_R_ADDRR: begin
        cmd_nxt.start = 1'b1;
        cmd_nxt.write = 1'b1;
        cmd_nxt.din   = {SLAVE_ADDR, 1'b1};
      end
      ST_R_BYTE: begin
        cmd_nxt.read   = 1'b1;
        cmd_nxt.ack_in = rd_last;
        cmd_nxt.stop   = rd_last;
      end
      ST_ABORT: cmd_nxt.stop = 1'b1;
      default: ;
    endcase
  end

  meteo_rx_buf #(.DEPTH(NBYTES)) u_rx_buf (
    .clk       (Clk_i),
    .rst_n     (Rst_n_i),
    .clr       (accept),
    .wr_en     (rx_wr),
    .wr_idx    (rd_idx_q),
    .wr_dat    (Dout_i),
    .bytes_dat (rx_dat)
  );

  always_ff @(posedge Clk_i or negedge Rst_n_i) begin
    if (!Rst_n_i) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= 16'd0;
      wr_idx_q   <= 2'd0;
      rd_idx_q   <= 3'd0;
      cmd_q      <= '0;
      press_q    <= 20'd0;
      temp_q     <= 20'd0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      en_q       <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (Al_i) begin
        // Bus lost: no STOP, the winning master owns the bus
        state_q    <= ST_IDLE;
        cmd_q      <= '0;
        wait_cnt_q <= 16'd0;
        en_q       <= 1'b0;
        err_q      <= 1'b1;
      end else if (nack) begin
        state_q <= ST_ABORT;
        cmd_q   <= '0;
      end else if (cmd_done) begin
        cmd_q <= '0;
        case (state_q)
          ST_W_ADDR: state_q <= ST_W_REG;
          ST_W_REG: begin
            wr_idx_q <= wr_idx_q + 2'd1;
            state_q  <= ST_W_DATA;
          end
          ST_W_DATA: begin
            if (wr_last) begin
              wait_cnt_q <= 16'd0;
              state_q    <= ST_W_WAIT;
            end else begin
              wr_idx_q <= wr_idx_q + 2'd1;
              state_q  <= ST_W_REG;
            end
          end
          ST_R_ADDRW: state_q <= ST_R_REG;
          ST_R_REG:   state_q <= ST_R_ADDRR;
          ST_R_ADDRR: begin
            rd_idx_q <= 3'd0;
            state_q  <= ST_R_BYTE;
          end
          ST_R_BYTE: begin
            if (rd_last) state_q <= ST_LATCH;
            else         rd_idx_q <= rd_idx_q + 3'd1;
          end
          ST_ABORT: begin
            err_q   <= 1'b1;
            en_q    <= 1'b0;
            state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end else if (cmd_issue && !cmd_busy) begin
        cmd_q <= cmd_nxt;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (accept) begin
              err_q    <= 1'b0;
              en_q     <= 1'b1;
              wr_idx_q <= 2'd0;
              rd_idx_q <= 3'd0;
              state_q  <= ST_W_ADDR;
            end
          end
          ST_W_WAIT: begin
            if (wait_cnt_q >= WAIT_LAST) begin
              wait_cnt_q <= 16'd0;
              state_q    <= ST_R_ADDRW;
            end else begin
              wait_cnt_q <= wait_cnt_q + 16'd1;
            end
          end
          ST_LATCH: begin
            press_q <= raw20(rx_dat[8*PRESS_IDX +: 8], rx_dat[8*(PRESS_IDX+1) +: 8],
                             rx_dat[8*(PRESS_IDX+2) +: 8]);
            temp_q  <= raw20(rx_dat[8*TEMP_IDX +: 8], rx_dat[8*(TEMP_IDX+1) +: 8],
                             rx_dat[8*(TEMP_IDX+2) +: 8]);
            valid_q <= 1'b1;
            en_q    <= 1'b0;
            state_q <= ST_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef METEO_HUM_EN
  logic [RAW_HUM_W-1:0] hum_q;
  always_ff @(posedge Clk_i or negedge Rst_n_i) begin
    if (!Rst_n_i)
      hum_q <= '0;
    else if (!Al_i && !cmd_busy && state_q == ST_LATCH)
      hum_q <= {rx_dat[8*HUM_IDX +: 8], rx_dat[8*(HUM_IDX+1) +: 8]};
  end
  assign Hum_o = hum_q;
  logic unused_bits;
  assign unused_bits = ^{rx_dat[8*(PRESS_IDX+2) +: 4], rx_dat[8*(TEMP_IDX+2) +: 4]};
`else
  logic unused_bits;
  assign unused_bits = ^{rx_dat[8*(PRESS_IDX+2) +: 4], rx_dat[8*(TEMP_IDX+2) +: 4], CTRL_HUM};
`endif

  assign Start_o      = cmd_q.start;
  assign Stop_o       = cmd_q.stop;
  assign Read_o       = cmd_q.read;
  assign Write_o      = cmd_q.write;
  assign AckIn_o      = cmd_q.ack_in;
  assign Din_o        = cmd_q.din;
  assign Enable_i2c_o = en_q;
  assign Press_o      = press_q;
  assign Temp_o       = temp_q;
  assign Valid_o      = valid_q;
  assign ErrFlag_o    = err_q;

endmodule

// File: tb/tb_meteo_i2c_seq.sv
// Directed bench for meteo_i2c_seq against a reactive BME280 byte-level slave model.
`timescale 1ns/1ps
module tb_meteo_i2c_seq;

  localparam logic [15:0] CW = 16'd20;
`ifdef METEO_HUM_EN
  localparam int NB = 8;
`else
  localparam int NB = 6;
`endif

  logic        Clk_i = 1'b0;
  logic        Rst_n_i = 1'b0;
  logic        Start_i = 1'b0;
  logic        CmdAck_i = 1'b0;
  logic        AckOut_i = 1'b0;
  logic [7:0]  Dout_i = 8'h00;
  logic        Al_i = 1'b0;
  logic        Start_o, Stop_o, Read_o, Write_o, AckIn_o;
  logic [7:0]  Din_o;
  logic        Enable_i2c_o, Valid_o, ErrFlag_o;
  logic [19:0] Press_o, Temp_o;
`ifdef METEO_HUM_EN
  logic [15:0] Hum_o;
`endif

  always #5 Clk_i = ~Clk_i;

  meteo_i2c_seq #(
    .SLAVE_ADDR (7'h76),
    .CTRL_MEAS  (8'h25),
    .CTRL_HUM   (8'h01),
    .CONV_WAIT  (CW)
  ) dut (
    .Clk_i        (Clk_i),
    .Rst_n_i      (Rst_n_i),
    .Start_i      (Start_i),
    .Start_o      (Start_o),
    .Stop_o       (Stop_o),
    .Read_o       (Read_o),
    .Write_o      (Write_o),
    .AckIn_o      (AckIn_o),
    .Din_o        (Din_o),
    .CmdAck_i     (CmdAck_i),
    .AckOut_i     (AckOut_i),
    .Dout_i       (Dout_i),
    .Al_i         (Al_i),
    .Enable_i2c_o (Enable_i2c_o),
    .Press_o      (Press_o),
    .Temp_o       (Temp_o),
`ifdef METEO_HUM_EN
    .Hum_o        (Hum_o),
`endif
    .Valid_o      (Valid_o),
    .ErrFlag_o    (ErrFlag_o)
  );

  int checks = 0;
  int errors = 0;

  // Slave model state
  logic [7:0]  mem [0:255];
  logic [6:0]  model_addr;
  logic [7:0]  ptr;
  bit          pend, addr_ok, last_ackin, want_rstart;
  int          dly, phase, cyc;
  int          reads, nacks, stops, stop_alone, valid_cnt;
  int          wstop_cyc, rstart_cyc;
  logic [19:0] v_press, v_temp;

  always @(negedge Clk_i) begin
    cyc++;
    CmdAck_i = 1'b0;
    AckOut_i = 1'b0;
    if (Valid_o) begin
      valid_cnt++;
      v_press = Press_o;
      v_temp  = Temp_o;
    end
    if (!Rst_n_i) begin
      pend = 1'b0;
      phase = 0;
      want_rstart = 1'b0;
    end else if (pend) begin
      if (dly > 0) dly--;
      else begin
        pend = 1'b0;
        if (Start_o || Stop_o || Read_o || Write_o) begin
          if (Stop_o) begin
            stops++;
            if (!Write_o && !Read_o) stop_alone++;
          end
          if (Write_o) begin
            if (Start_o) begin
              addr_ok = (Din_o[7:1] == model_addr);
              phase = 1;
              AckOut_i = !addr_ok;
            end else if (phase == 1) begin
              ptr = Din_o;
              phase = 2;
            end else begin
              mem[ptr] = Din_o;
              phase = 1;
            end
            if (Stop_o) begin
              wstop_cyc = cyc;
              want_rstart = 1'b1;
            end
          end
          if (Read_o) begin
            Dout_i = mem[ptr];
            ptr++;
            reads++;
            last_ackin = AckIn_o;
            if (AckIn_o) nacks++;
          end
          CmdAck_i = 1'b1;
        end
      end
    end else if (Start_o || Stop_o || Read_o || Write_o) begin
      pend = 1'b1;
      dly = 2;
    end
    if (want_rstart && Start_o) begin
      rstart_cyc = cyc;
      want_rstart = 1'b0;
    end
  end

  task automatic model_clear();
    reads = 0; nacks = 0; stops = 0; stop_alone = 0; valid_cnt = 0;
    wstop_cyc = 0; rstart_cyc = 0; last_ackin = 1'b0; want_rstart = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge Clk_i);
    Start_i = 1'b1;
    @(negedge Clk_i);
    Start_i = 1'b0;
  endtask

  task automatic wait_idle(output bit to);
    to = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge Clk_i);
      if (!Enable_i2c_o) begin
        to = 1'b0;
        break;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    model_addr = 7'h76;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'hF7] = 8'h65; mem[8'hF8] = 8'h5A; mem[8'hF9] = 8'hC0; mem[8'hFA] = 8'h7E;
    mem[8'hFB] = 8'hED; mem[8'hFC] = 8'h00; mem[8'hFD] = 8'h6A; mem[8'hFE] = 8'h3C;
    model_clear();
    Rst_n_i = 1'b0;
    repeat (3) @(negedge Clk_i);
    checks++; if ({Start_o, Stop_o, Read_o, Write_o, AckIn_o} !== 5'b0) begin errors++;
      $display("FAIL reset_cmd: got %b want 00000", {Start_o, Stop_o, Read_o, Write_o, AckIn_o}); end
    checks++; if (Din_o !== 8'h00) begin errors++; $display("FAIL reset_din: got %h want 00", Din_o); end
    checks++; if ({Valid_o, ErrFlag_o, Enable_i2c_o} !== 3'b000) begin errors++;
      $display("FAIL reset_flags: got %b want 000", {Valid_o, ErrFlag_o, Enable_i2c_o}); end
    checks++; if (Press_o !== 20'h0 || Temp_o !== 20'h0) begin errors++;
      $display("FAIL reset_data: got %h %h want 0 0", Press_o, Temp_o); end
`ifdef METEO_HUM_EN
    checks++; if (Hum_o !== 16'h0) begin errors++; $display("FAIL reset_hum: got %h want 0", Hum_o); end
`endif
    Rst_n_i = 1'b1;
    @(negedge Clk_i);
  endtask

  task automatic test_normal();
    bit to;
    model_clear();
    mem[8'hF4] = 8'h00;
    mem[8'hF2] = 8'h00;
    pulse_start();
    checks++; if (Enable_i2c_o !== 1'b1) begin errors++; $display("FAIL en_rise: got %b want 1", Enable_i2c_o); end
    wait_idle(to);
    checks++; if (to) begin errors++; $display("FAIL normal_timeout: got timeout want idle"); end
    checks++; if (valid_cnt != 1) begin errors++; $display("FAIL normal_valid_cnt: got %0d want 1", valid_cnt); end
    checks++; if (v_press !== 20'h655AC || v_temp !== 20'h7EED0) begin errors++;
      $display("FAIL normal_at_valid: got %h %h want 655ac 7eed0", v_press, v_temp); end
    checks++; if (Press_o !== 20'h655AC) begin errors++; $display("FAIL normal_press: got %h want 655ac", Press_o); end
    checks++; if (Temp_o !== 20'h7EED0) begin errors++; $display("FAIL normal_temp: got %h want 7eed0", Temp_o); end
    checks++; if (ErrFlag_o !== 1'b0) begin errors++; $display("FAIL normal_err: got %b want 0", ErrFlag_o); end
    checks++; if (reads != NB) begin errors++; $display("FAIL normal_reads: got %0d want %0d", reads, NB); end
    checks++; if (nacks != 1 || last_ackin != 1'b1) begin errors++;
      $display("FAIL normal_last_nack: got %0d/%b want 1/1", nacks, last_ackin); end
    checks++; if (stops != 2) begin errors++; $display("FAIL normal_stops: got %0d want 2", stops); end
    checks++; if (mem[8'hF4] !== 8'h25) begin errors++; $display("FAIL normal_ctrl_meas: got %h want 25", mem[8'hF4]); end
    checks++; if (rstart_cyc - wstop_cyc != int'(CW) + 2) begin errors++;
      $display("FAIL normal_wait_len: got %0d want %0d", rstart_cyc - wstop_cyc, int'(CW) + 2); end
`ifdef METEO_HUM_EN
    checks++; if (Hum_o !== 16'h6A3C) begin errors++; $display("FAIL normal_hum: got %h want 6a3c", Hum_o); end
    checks++; if (mem[8'hF2] !== 8'h01) begin errors++; $display("FAIL normal_ctrl_hum: got %h want 01", mem[8'hF2]); end
`endif
  endtask

  task automatic test_nack();
    bit to;
    model_clear();
    model_addr = 7'h77;
    pulse_start();
    wait_idle(to);
    checks++; if (to) begin errors++; $display("FAIL nack_timeout: got timeout want idle"); end
    checks++; if (ErrFlag_o !== 1'b1) begin errors++; $display("FAIL nack_err: got %b want 1", ErrFlag_o); end
    checks++; if (valid_cnt != 0) begin errors++; $display("FAIL nack_valid: got %0d want 0", valid_cnt); end
    checks++; if (stop_alone != 1 || stops != 1) begin errors++;
      $display("FAIL nack_stop: got %0d/%0d want 1/1", stop_alone, stops); end
    checks++; if (reads != 0) begin errors++; $display("FAIL nack_reads: got %0d want 0", reads); end
    checks++; if (Press_o !== 20'h655AC || Temp_o !== 20'h7EED0) begin errors++;
      $display("FAIL nack_hold: got %h %h want 655ac 7eed0", Press_o, Temp_o); end
    model_addr = 7'h76;
  endtask

  task automatic test_start_in_read();
    bit to;
    bit hit;
    model_clear();
    pulse_start();
    hit = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge Clk_i);
      if (reads >= 2) begin hit = 1'b1; break; end
    end
    checks++; if (!hit) begin errors++; $display("FAIL rdstart_reach: got timeout want R_BYTE"); end
    Start_i = 1'b1;
    @(negedge Clk_i);
    Start_i = 1'b0;
    wait_idle(to);
    checks++; if (to) begin errors++; $display("FAIL rdstart_timeout: got timeout want idle"); end
    checks++; if (ErrFlag_o !== 1'b0) begin errors++; $display("FAIL rdstart_err_clr: got %b want 0", ErrFlag_o); end
    repeat (40) @(negedge Clk_i);
    checks++; if (valid_cnt != 1 || reads != NB) begin errors++;
      $display("FAIL rdstart_once: got %0d valid %0d reads want 1 %0d", valid_cnt, reads, NB); end
    checks++; if (Enable_i2c_o !== 1'b0) begin errors++; $display("FAIL rdstart_idle: got %b want 0", Enable_i2c_o); end
  endtask

  task automatic test_start_on_valid();
    bit hit;
    model_clear();
    pulse_start();
    hit = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge Clk_i);
      if (Valid_o) begin hit = 1'b1; break; end
    end
    checks++; if (!hit) begin errors++; $display("FAIL onvalid_reach: got timeout want Valid_o"); end
    Start_i = 1'b1;
    @(negedge Clk_i);
    Start_i = 1'b0;
    checks++; if (Valid_o !== 1'b0 || Enable_i2c_o !== 1'b0) begin errors++;
      $display("FAIL onvalid_ignored: got valid %b en %b want 0 0", Valid_o, Enable_i2c_o); end
    repeat (20) @(negedge Clk_i);
    checks++; if (valid_cnt != 1) begin errors++; $display("FAIL onvalid_cnt: got %0d want 1", valid_cnt); end
  endtask

  task automatic test_reset_mid();
    bit to;
    bit hit;
    model_clear();
    pulse_start();
    hit = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge Clk_i);
      if (want_rstart) begin hit = 1'b1; break; end
    end
    checks++; if (!hit) begin errors++; $display("FAIL rstmid_reach: got timeout want W_WAIT"); end
    repeat (3) @(negedge Clk_i);
    Rst_n_i = 1'b0;
    @(negedge Clk_i);
    checks++; if ({Start_o, Stop_o, Read_o, Write_o, Enable_i2c_o, ErrFlag_o, Valid_o} !== 7'b0) begin errors++;
      $display("FAIL rstmid_ctl: got %b want 0", {Start_o, Stop_o, Read_o, Write_o, Enable_i2c_o, ErrFlag_o, Valid_o}); end
    checks++; if (Press_o !== 20'h0 || Temp_o !== 20'h0 || Din_o !== 8'h0) begin errors++;
      $display("FAIL rstmid_data: got %h %h %h want 0", Press_o, Temp_o, Din_o); end
    Rst_n_i = 1'b1;
    @(negedge Clk_i);
    model_clear();
    pulse_start();
    wait_idle(to);
    checks++; if (to) begin errors++; $display("FAIL rstmid_timeout: got timeout want idle"); end
    checks++; if (valid_cnt != 1 || Press_o !== 20'h655AC || Temp_o !== 20'h7EED0) begin errors++;
      $display("FAIL rstmid_rerun: got %0d %h %h want 1 655ac 7eed0", valid_cnt, Press_o, Temp_o); end
  endtask

  task automatic test_al();
    bit hit;
    model_clear();
    pulse_start();
    hit = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge Clk_i);
      if (Write_o && !Start_o && Din_o == 8'hF7) begin hit = 1'b1; break; end
    end
    checks++; if (!hit) begin errors++; $display("FAIL al_reach: got timeout want R_REG"); end
    Al_i = 1'b1;
    @(negedge Clk_i);
    Al_i = 1'b0;
    checks++; if (ErrFlag_o !== 1'b1 || Enable_i2c_o !== 1'b0) begin errors++;
      $display("FAIL al_state: got err %b en %b want 1 0", ErrFlag_o, Enable_i2c_o); end
    checks++; if ({Start_o, Stop_o, Read_o, Write_o} !== 4'b0) begin errors++;
      $display("FAIL al_cmd: got %b want 0000", {Start_o, Stop_o, Read_o, Write_o}); end
    repeat (20) @(negedge Clk_i);
    checks++; if (stops != 1 || valid_cnt != 0) begin errors++;
      $display("FAIL al_nostop: got %0d stops %0d valid want 1 0", stops, valid_cnt); end
    checks++; if (ErrFlag_o !== 1'b1) begin errors++; $display("FAIL al_err_hold: got %b want 1", ErrFlag_o); end
  endtask

  task automatic test_back_to_back();
    bit to;
    model_clear();
    pulse_start();
    wait_idle(to);
    checks++; if (to || ErrFlag_o !== 1'b0) begin errors++;
      $display("FAIL b2b_first: got to %b err %b want 0 0", to, ErrFlag_o); end
    pulse_start();
    wait_idle(to);
    checks++; if (to || valid_cnt != 2 || reads != 2 * NB) begin errors++;
      $display("FAIL b2b_second: got to %b valid %0d reads %0d want 0 2 %0d", to, valid_cnt, reads, 2 * NB); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_normal();
    test_nack();
    test_start_in_read();
    test_start_on_valid();
    test_reset_mid();
    test_al();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
